// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//
// Converts an 8-bit binary value to three BCD digits with a sequential
// shift-add-3 (double dabble) engine, one bit per clock, and time-multiplexes
// the result onto a 4-digit common-anode 7-segment display.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-high
//   value  in   8  unsigned value to display (0..255)
//   load   in   1  single-cycle request; accepted only while idle
//   busy   out  1  high for exactly 8 cycles while a conversion runs
//   digit  out  4  BCD digit for the decoder; 4'hF means blank
//   an     out  4  active-low digit enables, one-hot-low; an[0] = ones digit
//
// Handshake: load is a request sampled on a rising edge. It is accepted only
// when busy is low; a load seen while busy is high (including the cycle of the
// final shift) is dropped, not queued. busy rises on the accepting edge and
// falls on the edge that writes the new digits into the display register.
//
// Conversion and scanning are independent: the refresh counter and scan index
// never stall or restart because of a conversion.

module bcd_display_scanner #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic [3:0] digit,
  output logic [3:0] an
);

  localparam int CW = $clog2(REFRESH_CYCLES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  shreg;     // captured value, consumed MSB first
  logic [11:0] work;      // BCD working register {hundreds, tens, ones}
  logic [2:0]  bit_cnt;   // shifts already done in this conversion
  logic [11:0] disp;      // displayed digits, updated atomically

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;

  // Add 3 to a nibble that is 5 or more so that the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  logic [11:0] work_adj;
  logic [11:0] work_next;

  always_comb begin
    work_adj  = {add3(work[11:8]), add3(work[7:4]), add3(work[3:0])};
    // Whole-vector shift; the hundreds nibble never exceeds 2 for 8-bit input,
    // so nothing meaningful falls off the top.
    work_next = (work_adj << 1) | {11'd0, shreg[7]};
  end

  // Conversion FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      shreg   <= 8'd0;
      work    <= 12'd0;
      bit_cnt <= 3'd0;
      disp    <= 12'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            shreg   <= value;
            work    <= 12'd0;
            bit_cnt <= 3'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work    <= work_next;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            disp  <= work_next;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh counter and scan index.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
    end else if (refresh_cnt == CW'(REFRESH_CYCLES - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  // Digit select with leading-zero blanking; same cycle as an.
  always_comb begin
    an    = ~(4'b0001 << scan_idx);
    digit = 4'hF;
    unique case (scan_idx)
      2'd0: digit = disp[3:0];
      2'd1: digit = (disp[11:8] == 4'd0 && disp[7:4] == 4'd0) ? 4'hF : disp[7:4];
      2'd2: digit = (disp[11:8] == 4'd0) ? 4'hF : disp[11:8];
      2'd3: digit = 4'hF;
      default: digit = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

  localparam int R = 4;

  logic       clk;
  logic       reset;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic [3:0] digit;
  logic [3:0] an;

  int total;
  int bad;
  int k;  // rising edges since the last reset edge

  logic [3:0] obs_digit [4];
  logic [3:0] obs_an    [4];

  bcd_display_scanner #(.REFRESH_CYCLES(R)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .busy  (busy),
    .digit (digit),
    .an    (an)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  // ---------------- reference model ----------------
  function automatic int exp_idx(input int edges);
    return (edges / R) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    logic [3:0] a;
    a = 4'b1111;
    a[idx] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_digit(input int v, input int idx);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (idx)
      0:       return 4'(o);
      1:       return (h == 0 && t == 0) ? 4'hF : 4'(t);
      2:       return (h == 0) ? 4'hF : 4'(h);
      default: return 4'hF;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents load for exactly one edge; returns #1 after that edge.
  task automatic start_load(input logic [7:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Returns #1 after the edge where busy falls; w = cycles busy was seen high.
  task automatic measure_busy(output int w);
    w = busy ? 1 : 0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk);
      #1;
      if (busy) w++;
    end
  endtask

  // Observes one full scan rotation and records what each index showed.
  task automatic capture_scan();
    for (int i = 0; i < 4; i++) begin
      obs_digit[i] = 4'hx;
      obs_an[i]    = 4'hx;
    end
    for (int c = 0; c < 4 * R; c++) begin
      @(posedge clk);
      #1;
      obs_digit[exp_idx(k)] = digit;
      obs_an[exp_idx(k)]    = an;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    total++;
    if (an !== 4'b1110) begin
      bad++; $display("FAIL reset_an got=%b want=1110", an);
    end
    total++;
    if (digit !== 4'd0) begin
      bad++; $display("FAIL reset_digit got=%h want=0", digit);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_scan();
    apply_reset();
    for (int c = 0; c < 5 * R; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (an !== exp_an(exp_idx(k))) begin
        bad++; $display("FAIL scan_an edge=%0d got=%b want=%b", k, an, exp_an(exp_idx(k)));
      end
      total++;
      if (digit !== exp_digit(0, exp_idx(k))) begin
        bad++; $display("FAIL scan_digit edge=%0d got=%h want=%h", k, digit, exp_digit(0, exp_idx(k)));
      end
    end
  endtask

  task automatic test_convert_255();
    int w;
    start_load(8'd255);
    measure_busy(w);
    total++;
    if (w !== 8) begin
      bad++; $display("FAIL busy_width_255 got=%0d want=8", w);
    end
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_digit[i] !== exp_digit(255, i)) begin
        bad++; $display("FAIL digit_255 idx=%0d got=%h want=%h", i, obs_digit[i], exp_digit(255, i));
      end
    end
  endtask

  task automatic test_blanking();
    int vals [3] = '{7, 100, 10};
    int w;
    foreach (vals[n]) begin
      start_load(8'(vals[n]));
      measure_busy(w);
      capture_scan();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_digit[i] !== exp_digit(vals[n], i)) begin
          bad++; $display("FAIL blank v=%0d idx=%0d got=%h want=%h", vals[n], i, obs_digit[i], exp_digit(vals[n], i));
        end
        total++;
        if (obs_an[i] !== exp_an(i)) begin
          bad++; $display("FAIL blank_an idx=%0d got=%b want=%b", i, obs_an[i], exp_an(i));
        end
      end
    end
  endtask

  task automatic test_load_while_busy();
    start_load(8'd200);
    repeat (2) begin @(posedge clk); #1; end
    value = 8'd45; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;          // shift edge 3
    repeat (4) begin @(posedge clk); #1; end
    load = 1'b1;
    @(posedge clk); #1 load = 1'b0;          // shift edge 8
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_after_8 got=%b want=0", busy);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL late_load_queued busy got=%b want=0", busy);
    end
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_digit[i] !== exp_digit(200, i)) begin
        bad++; $display("FAIL ignore idx=%0d got=%h want=%h", i, obs_digit[i], exp_digit(200, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    start_load(8'd123);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;        // shift edge 5
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_busy got=%b want=0", busy);
    end
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_digit[i] !== exp_digit(0, i)) begin
        bad++; $display("FAIL reset_mid idx=%0d got=%h want=%h", i, obs_digit[i], exp_digit(0, i));
      end
    end
    start_load(8'd123);
    measure_busy(w);
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_digit[i] !== exp_digit(123, i)) begin
        bad++; $display("FAIL reload_123 idx=%0d got=%h want=%h", i, obs_digit[i], exp_digit(123, i));
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1; load = 1'b1; value = 8'd99;
    @(posedge clk); #1;
    reset = 1'b0; load = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_priority busy got=%b want=0", busy);
    end
    repeat (10) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b0 || an !== exp_an(exp_idx(k)) || digit !== exp_digit(0, exp_idx(k))) begin
      bad++; $display("FAIL reset_priority_disp busy=%b digit=%h want busy=0 digit=%h", busy, digit, exp_digit(0, exp_idx(k)));
    end
  endtask

  task automatic test_random();
    int v, prev, w;
    prev = 0;
    for (int n = 0; n < 24; n++) begin
      v = $urandom_range(0, 255);
      start_load(8'(v));
      // During conversion the old digits must stay on display.
      w = busy ? 1 : 0;
      for (int i = 0; i < 20 && busy; i++) begin
        total++;
        if (digit !== exp_digit(prev, exp_idx(k))) begin
          bad++; $display("FAIL hold v=%0d prev=%0d got=%h want=%h", v, prev, digit, exp_digit(prev, exp_idx(k)));
        end
        @(posedge clk); #1;
        if (busy) w++;
      end
      total++;
      if (w !== 8) begin
        bad++; $display("FAIL rand_busy v=%0d got=%0d want=8", v, w);
      end
      capture_scan();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_digit[i] !== exp_digit(v, i)) begin
          bad++; $display("FAIL rand v=%0d idx=%0d got=%h want=%h", v, i, obs_digit[i], exp_digit(v, i));
        end
      end
      prev = v;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    load  = 1'b0;
    value = 8'd0;
    test_reset();
    test_scan();
    test_convert_255();
    test_blanking();
    test_load_while_busy();
    test_reset_mid();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter REFRESH_CYCLES, default 100000, clk cycles each digit is enabled per scan step (minimum 2).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 value  input  8  unsigned binary value to display (0..255).
REQ-005 load  input  1  single-cycle request to convert and display value.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 digit  output  4  BCD digit for the downstream 7-segment decoder D input; 4'hF means blank.
REQ-008 an  output  4  active-low digit enables, one-hot-low; an[0] is the ones (rightmost) digit.

Function
REQ-009 The block SHALL convert value to three BCD digits (hundreds, tens, ones) by sequential shift-add-3 (double dabble), one bit per clk.
REQ-010 FSM states SHALL be IDLE and SHIFT; IDLE->SHIFT on load=1, SHIFT->IDLE after the 8th shift.
REQ-011 On the edge sampling load=1 in IDLE, the block SHALL capture value, clear the BCD working register, and set busy=1.
REQ-012 Each subsequent edge in SHIFT SHALL add 3 to any working BCD nibble >=5, then shift left one bit, taking in the next captured bit, MSB first.
REQ-013 On the 8th shift edge, the block SHALL write the result into the display register and clear busy in the same edge; busy is high for exactly 8 cycles.
REQ-014 load while busy=1 SHALL be ignored, including the cycle of the 8th shift; the value is not queued.
REQ-015 Between completions the display register SHALL hold its contents unchanged; all three digits update atomically.
REQ-016 A refresh counter SHALL count 0..REFRESH_CYCLES-1 and wrap; at the terminal count the 2-bit scan index SHALL advance 0->1->2->3->0.
REQ-017 an SHALL be all ones except an[index]=0; exactly one digit is enabled at all times.
REQ-018 digit SHALL be combinational from scan index and display register, with no extra latency versus an.
REQ-019 Index 0 SHALL output ones, never blanked.
REQ-020 Index 1 SHALL output tens, or 4'hF if hundreds=0 and tens=0.
REQ-021 Index 2 SHALL output hundreds, or 4'hF if hundreds=0.
REQ-022 Index 3 SHALL always output 4'hF.
REQ-023 Conversion and scanning SHALL run independently; a conversion never stalls or resets the refresh counter.

Reset
REQ-024 On reset=1, the block SHALL clear the refresh counter, scan index, FSM (IDLE) and display register (000), and set busy=0.
REQ-025 After reset, outputs SHALL be an=4'b1110 and digit=4'd0.
REQ-026 Reset mid-conversion SHALL abort the conversion, leaving display 000 and busy=0.
REQ-027 Reset SHALL take priority over load in the same cycle.

Verification
REQ-028 Reset, REFRESH_CYCLES=4 -> an steps 1110,1101,1011,0111,1110 every 4 clocks; digit sequence 0,F,F,F.
REQ-029 load with value=255 -> busy high exactly 8 cycles; then index0/1/2/3 show digit 5,5,2,F.
REQ-030 load with value=7 -> digits 7,F,F,F; then value=100 -> digits 0,0,1,F; then value=10 -> digits 0,1,F,F.
REQ-031 load 200, then load 45 on shift cycles 3 and 8 -> both ignored; display shows 0,0,2,F.
REQ-032 load 123, then reset on shift cycle 5 -> busy=0, display 0,F,F,F; a following load 123 -> 3,2,1,F.
REQ-033 Randomized 0..255 loads -> displayed hundreds*100+tens*10+ones equals value; busy width is always 8.
